// File: rtl/demux_deserializer_1to8_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and helpers for the 1:8 serial-to-parallel deserializer.
//   DEFAULT_WIDTH : default output word width
//   idx_width()   : width of the bit-index counter for a given word width
//   bit_pos()     : maps arrival order k to the bit position inside the word
// Optional macro DESER_MSB_FIRST_EN selects MSB-first placement (bit k lands
// at position WIDTH-1-k); without it bits are placed LSB-first.
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int bit_pos(input int k, input int width);
`ifdef DESER_MSB_FIRST_EN
        return width - 1 - k;
`else
        return k + 0 * width;
`endif
    endfunction

endpackage

// File: rtl/demux_deserializer_1to8_index_ctr.sv
// -----------------------------------------------------------------------------
// deser_index_ctr
// Arrival-order bit index for the deserializer.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear to 0 (flush)
//   realign  : start-of-word beat accepted; next position is 1
//   inc      : ordinary beat accepted; advance, wrapping to 0 after the last bit
//   idx      : index of the next bit to be written
//   last     : idx points at the final bit of the word
// Priority: rst > clear > realign > inc.
// -----------------------------------------------------------------------------
module deser_index_ctr
    import demux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             realign,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (realign) begin
            idx <= IDX_W'(1);
        end else if (inc) begin
            // Wrap happens only on word completion.
            idx <= last ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/demux_deserializer_1to8.sv
// -----------------------------------------------------------------------------
// demux_deserializer_1to8
// Serial-to-parallel 1:WIDTH demultiplexer with a single registered output slot.
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : synchronous clear of the partial word and the output slot
//   in_bit      : serial data bit
//   in_first    : in_bit is bit 0 of a new word (realigns the frame)
//   in_valid    : input beat valid
//   in_ready    : input beat accepted when in_valid && in_ready
//   out_data    : completed word
//   out_valid   : out_data holds an undrained word
//   out_ready   : downstream takes the word when out_valid && out_ready
//   idx         : arrival index of the next bit
//   err_realign : one-cycle pulse after in_first is accepted mid-word
// Optional macro DESER_MSB_FIRST_EN: MSB-first bit placement.
// -----------------------------------------------------------------------------
module demux_deserializer_1to8
    import demux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_bit,
    input  logic             in_first,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx,
    output logic             err_realign
);

    localparam logic [IDX_W-1:0] POS0 = IDX_W'(bit_pos(0, WIDTH));

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_ins;
    logic [WIDTH-1:0] acc_first;
    logic [IDX_W-1:0] pos_cur;
    logic             last;
    logic             accept;
    logic             complete;

    // Only the final bit of a word can stall, and only while the previous word
    // is still held; a start-of-word beat is never stalled.
    assign in_ready = !flush && (in_first || !(last && out_valid && !out_ready));
    assign accept   = in_valid && in_ready;
    assign complete = accept && !in_first && last;
    assign pos_cur  = IDX_W'(bit_pos(int'(idx), WIDTH));

    deser_index_ctr #(
        .WIDTH (WIDTH)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .realign (accept && in_first),
        .inc     (accept && !in_first),
        .idx     (idx),
        .last    (last)
    );

    // Accumulator with the current bit inserted at its mapped position.
    always_comb begin
        acc_ins          = acc;
        acc_ins[pos_cur] = in_bit;
    end

    // Fresh word started by in_first: everything but position 0 discarded.
    always_comb begin
        acc_first       = '0;
        acc_first[POS0] = in_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            err_realign <= 1'b0;
        end else if (flush) begin
            acc         <= '0;
            out_valid   <= 1'b0;
            err_realign <= 1'b0;
        end else begin
            err_realign <= accept && in_first && (idx != '0);

            if (accept && in_first) begin
                acc <= acc_first;
            end else if (complete) begin
                acc      <= '0;
                out_data <= acc_ins;
            end else if (accept) begin
                acc <= acc_ins;
            end

            // A completion in the drain cycle reloads the slot with no bubble.
            if (complete) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
